// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: left-to-right square-and-multiply modular exponentiation
// built on a bit-serial interleaved modular multiplier (one operand bit per cycle).
module rsa_modexp_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             en_rsa,
  input  logic             rst_rsa,
  input  logic [WIDTH-1:0] plain_text,
  input  logic [WIDTH-1:0] exp_key,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] cipher_text,
  output logic             eoc_rsa_unit
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_SQR, S_MUL, S_DONE} state_t;
  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_p, r_e, r_m, r_b, r_r, r_acc, r_ct;
  logic [WIDTH-1:0] w_p_n, w_e_n, w_m_n, w_b_n, w_r_n, w_acc_n, w_ct_n;
  logic [IW-1:0]    r_j, r_i, w_j_n, w_i_n;
  logic [WIDTH-1:0] w_a, w_bop, w_mm;
  logic [WIDTH:0]   w_m1, w_t0, w_t1, w_t2;
  logic             w_run, w_clr;
  assign w_run        = ena & en_rsa & rst_rsa;
  assign w_clr        = ena & ~rst_rsa;
  assign cipher_text  = r_ct;
  assign eoc_rsa_unit = (r_state == S_DONE);
  // One multiplier step: double, reduce, conditionally add a, reduce (all WIDTH+1 bits)
  assign w_a   = (r_state == S_PREP) ? WIDTH'(1) : r_r;
  assign w_bop = (r_state == S_PREP) ? r_p : (r_state == S_SQR) ? r_r : r_b;
  assign w_m1  = {1'b0, r_m};
  assign w_t0  = {r_acc, 1'b0};
  assign w_t1  = (w_t0 >= w_m1) ? w_t0 - w_m1 : w_t0;
  assign w_t2  = w_t1 + (w_bop[r_j] ? {1'b0, w_a} : '0);
  assign w_mm  = WIDTH'((w_t2 >= w_m1) ? w_t2 - w_m1 : w_t2);
  always_comb begin
    w_state_n = r_state;
    w_p_n     = r_p;
    w_e_n     = r_e;
    w_m_n     = r_m;
    w_b_n     = r_b;
    w_r_n     = r_r;
    w_acc_n   = r_acc;
    w_ct_n    = r_ct;
    w_j_n     = r_j;
    w_i_n     = r_i;
    if (w_clr) begin
      w_state_n = S_IDLE;
    end else if (w_run) begin
      case (r_state)
        S_IDLE: begin
          w_p_n = plain_text;
          w_e_n = exp_key;
          w_m_n = modulus;
          if (modulus < WIDTH'(2)) begin
            w_state_n = S_DONE;
            w_ct_n    = '0;
          end else begin
            w_state_n = S_PREP;
            w_r_n     = WIDTH'(1);
            w_acc_n   = '0;
            w_j_n     = IW'(WIDTH - 1);
            w_i_n     = IW'(WIDTH - 1);
          end
        end
        S_PREP, S_SQR, S_MUL: begin
          w_acc_n = w_mm;
          w_j_n   = r_j - 1'b1;
          if (r_j == '0) begin
            w_acc_n = '0;
            w_j_n   = IW'(WIDTH - 1);
            if (r_state == S_PREP) begin
              w_b_n     = w_mm;
              w_state_n = S_SQR;
            end else begin
              w_r_n = w_mm;
              // Square finished on a set exponent bit: multiply before advancing
              if (r_state == S_SQR && r_e[r_i]) begin
                w_state_n = S_MUL;
              end else if (r_i == '0) begin
                w_state_n = S_DONE;
                w_ct_n    = w_mm;
              end else begin
                w_i_n     = r_i - 1'b1;
                w_state_n = S_SQR;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_e     <= '0;
      r_m     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_acc   <= '0;
      r_ct    <= '0;
      r_j     <= '0;
      r_i     <= '0;
    end else begin
      r_state <= w_state_n;
      r_p     <= w_p_n;
      r_e     <= w_e_n;
      r_m     <= w_m_n;
      r_b     <= w_b_n;
      r_r     <= w_r_n;
      r_acc   <= w_acc_n;
      r_ct    <= w_ct_n;
      r_j     <= w_j_n;
      r_i     <= w_i_n;
    end
  end
endmodule

// File: tb/tb_rsa_modexp_core.sv
// tb_rsa_modexp_core: randomized and directed checks of rsa_modexp_core against
// a plain-arithmetic modular exponentiation and latency model.
module tb_rsa_modexp_core;
  logic       clk = 1'b0;
  logic       rstb, ena, en_rsa, rst_rsa;
  logic [7:0] plain_text, exp_key, modulus, cipher_text;
  logic       eoc_rsa_unit;
  int         n_checks = 0;
  int         n_errors = 0;

  rsa_modexp_core #(.WIDTH(8)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .en_rsa(en_rsa), .rst_rsa(rst_rsa),
    .plain_text(plain_text), .exp_key(exp_key), .modulus(modulus),
    .cipher_text(cipher_text), .eoc_rsa_unit(eoc_rsa_unit)
  );

  always #5 clk = ~clk;

  // Right-to-left binary exponentiation with ordinary integer arithmetic
  function automatic logic [7:0] ref_exp(input logic [7:0] p, e, m);
    longint unsigned r, b;
    if (m < 2) return 8'd0;
    r = 1;
    b = p % m;
    for (int k = 0; k < 8; k++) begin
      if (e[k]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return 8'(r);
  endfunction

  function automatic int ref_lat(input logic [7:0] e, m);
    return (m < 2) ? 1 : 1 + 8 + 8 * (8 + $countones(e));
  endfunction

  // Starts a conversion from IDLE and counts edges until eoc, an abort point or a bound.
  // Operand inputs are scrambled after capture; optional 10-edge freeze inside SQR.
  task automatic convert(input logic [7:0] p, e, m, input bit freeze, input int abort_at,
                         output int lat);
    logic [7:0] ct_before;
    @(negedge clk);
    plain_text = p; exp_key = e; modulus = m;
    ena = 1'b1; en_rsa = 1'b1; rst_rsa = 1'b1;
    ct_before = cipher_text;
    lat = 0;
    while (lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (eoc_rsa_unit || lat == abort_at) break;
      plain_text = 8'($urandom); exp_key = 8'($urandom); modulus = 8'($urandom);
      if (freeze) begin
        ena    = !(lat >= 20 && lat < 25);
        en_rsa = !(lat >= 25 && lat < 30);
      end
      n_checks++;
      if (cipher_text !== ct_before) begin
        n_errors++;
        $display("FAIL ct_hold edge %0d: got %0d want %0d", lat, cipher_text, ct_before);
      end
    end
  endtask

  task automatic soft_clear();
    @(negedge clk);
    ena = 1'b1; rst_rsa = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_rsa = 1'b1; en_rsa = 1'b0;
  endtask

  task automatic test_reset();
    rstb = 1'b0; ena = 1'b0; en_rsa = 1'b0; rst_rsa = 1'b0;
    plain_text = 8'd0; exp_key = 8'd0; modulus = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (cipher_text !== 8'd0 || eoc_rsa_unit !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: ct=%0d eoc=%b want 0/0", cipher_text, eoc_rsa_unit);
    end
    @(negedge clk);
    rstb = 1'b1; rst_rsa = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (eoc_rsa_unit !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_no_run: eoc=%b want 0", eoc_rsa_unit);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] tp[4] = '{8'd4, 8'd16, 8'd37, 8'd5};
    logic [7:0] te[4] = '{8'd7, 8'd3, 8'd1, 8'd0};
    int lat;
    for (int k = 0; k < 4; k++) begin
      convert(tp[k], te[k], 8'd33, 1'b0, 0, lat);
      n_checks++;
      if (lat !== ref_lat(te[k], 8'd33) || cipher_text !== ref_exp(tp[k], te[k], 8'd33)) begin
        n_errors++;
        $display("FAIL vec%0d: lat=%0d ct=%0d want lat=%0d ct=%0d", k, lat, cipher_text,
                 ref_lat(te[k], 8'd33), ref_exp(tp[k], te[k], 8'd33));
      end
      if (k == 0) begin
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (eoc_rsa_unit !== 1'b1 || cipher_text !== 8'd16) begin
          n_errors++;
          $display("FAIL done_hold: eoc=%b ct=%0d want 1/16", eoc_rsa_unit, cipher_text);
        end
      end
      soft_clear();
      n_checks++;
      if (eoc_rsa_unit !== 1'b0 || cipher_text !== ref_exp(tp[k], te[k], 8'd33)) begin
        n_errors++;
        $display("FAIL clear_keep%0d: eoc=%b ct=%0d", k, eoc_rsa_unit, cipher_text);
      end
    end
  endtask

  task automatic test_degenerate();
    int lat;
    for (int k = 0; k < 2; k++) begin
      convert(8'd4, 8'd7, 8'd33, 1'b0, 0, lat);
      soft_clear();
      convert(8'($urandom), 8'($urandom), 8'(k), 1'b0, 0, lat);
      n_checks++;
      if (lat !== 1 || cipher_text !== 8'd0 || eoc_rsa_unit !== 1'b1) begin
        n_errors++;
        $display("FAIL degen_m%0d: lat=%0d ct=%0d eoc=%b want 1/0/1", k, lat, cipher_text,
                 eoc_rsa_unit);
      end
      soft_clear();
    end
  endtask

  task automatic test_freeze();
    int lat;
    convert(8'd4, 8'd13, 8'd33, 1'b1, 0, lat);
    n_checks++;
    if (lat !== 107 || cipher_text !== 8'd31) begin
      n_errors++;
      $display("FAIL freeze: lat=%0d ct=%0d want 107/31", lat, cipher_text);
    end
    soft_clear();
  endtask

  task automatic test_soft_clear();
    int lat;
    convert(8'd4, 8'd7, 8'd33, 1'b0, 0, lat);
    soft_clear();
    convert(8'd4, 8'd13, 8'd33, 1'b0, 40, lat);
    rst_rsa = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (eoc_rsa_unit !== 1'b0 || cipher_text !== 8'd16) begin
      n_errors++;
      $display("FAIL midclear: eoc=%b ct=%0d want 0/16", eoc_rsa_unit, cipher_text);
    end
    rst_rsa = 1'b1; en_rsa = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (eoc_rsa_unit !== 1'b0) begin
      n_errors++;
      $display("FAIL midclear_idle: eoc=%b want 0", eoc_rsa_unit);
    end
    convert(8'd4, 8'd13, 8'd33, 1'b0, 0, lat);
    n_checks++;
    if (lat !== 97 || cipher_text !== 8'd31) begin
      n_errors++;
      $display("FAIL restart: lat=%0d ct=%0d want 97/31", lat, cipher_text);
    end
    soft_clear();
  endtask

  task automatic test_async_reset();
    int lat;
    convert(8'd4, 8'd7, 8'd33, 1'b0, 0, lat);
    soft_clear();
    convert(8'd4, 8'd7, 8'd33, 1'b0, 60, lat);
    #2 rstb = 1'b0;
    #1;
    n_checks++;
    if (cipher_text !== 8'd0 || eoc_rsa_unit !== 1'b0) begin
      n_errors++;
      $display("FAIL arst_mul: ct=%0d eoc=%b want 0/0", cipher_text, eoc_rsa_unit);
    end
    @(negedge clk);
    rstb = 1'b1; en_rsa = 1'b0;
    convert(8'd16, 8'd3, 8'd33, 1'b0, 0, lat);
    n_checks++;
    if (lat !== 89 || cipher_text !== 8'd4) begin
      n_errors++;
      $display("FAIL post_arst: lat=%0d ct=%0d want 89/4", lat, cipher_text);
    end
    #2 rstb = 1'b0;
    #1;
    n_checks++;
    if (cipher_text !== 8'd0 || eoc_rsa_unit !== 1'b0) begin
      n_errors++;
      $display("FAIL arst_done: ct=%0d eoc=%b want 0/0", cipher_text, eoc_rsa_unit);
    end
    @(negedge clk);
    rstb = 1'b1; en_rsa = 1'b0;
    convert(8'd4, 8'd13, 8'd33, 1'b0, 0, lat);
    n_checks++;
    if (lat !== 97 || cipher_text !== 8'd31) begin
      n_errors++;
      $display("FAIL arst_rerun: lat=%0d ct=%0d want 97/31", lat, cipher_text);
    end
    soft_clear();
  endtask

  task automatic test_random();
    logic [7:0] p, e, m;
    int lat;
    for (int k = 0; k < 20; k++) begin
      p = 8'($urandom);
      e = 8'($urandom);
      m = (k % 4 == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom);
      convert(p, e, m, 1'($urandom_range(0, 1)), 0, lat);
      n_checks++;
      if (lat !== ref_lat(e, m) + ((m >= 2 && lat > 30) ? 10 : 0) - ((lat <= 30 || m < 2) ? 0 : 0)
          && lat !== ref_lat(e, m)) begin
        n_errors++;
        $display("FAIL rnd_lat%0d: p=%0d e=%0d m=%0d lat=%0d want %0d(+10 if frozen)", k, p, e,
                 m, lat, ref_lat(e, m));
      end
      n_checks++;
      if (cipher_text !== ref_exp(p, e, m) || eoc_rsa_unit !== 1'b1) begin
        n_errors++;
        $display("FAIL rnd_ct%0d: p=%0d e=%0d m=%0d ct=%0d eoc=%b want %0d", k, p, e, m,
                 cipher_text, eoc_rsa_unit, ref_exp(p, e, m));
      end
      soft_clear();
      ena = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_degenerate();
    test_freeze();
    test_soft_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
